// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter with a one-entry holding register and back-to-back framing.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 tx_valid,
`ifdef UART_TX_BREAK_EN
    input  logic                 send_break,
`endif
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 tx_done
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
        $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] S_BREAK  = 3'd5;
`endif

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 par_q, par_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 out_q, out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 btick_q;
    logic                 tick;
    logic                 load;

    assign tick     = baud_tick & ~btick_q;
    assign tx_ready = ~hold_full_q;
    assign tx_out   = out_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        par_d       = par_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load        = 1'b0;

        // Accept needs an empty hold and unload needs a full one, so they never collide.
        if (tx_valid && !hold_full_q) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        if (tick) begin
            case (state_q)
                S_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (send_break) begin
                        state_d = S_BREAK;
                        out_d   = 1'b0;
                        busy_d  = 1'b1;
                    end else
`endif
                    if (hold_full_q) load = 1'b1;
                end
                S_START: begin
                    out_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    if (cnt_q == 4'(DATA_BITS - 1)) begin
                        if (PARITY_MODE != 0) begin
                            out_d   = par_q;
                            state_d = S_PARITY;
                        end else begin
                            out_d   = 1'b1;
                            cnt_d   = '0;
                            state_d = S_STOP;
                        end
                    end else begin
                        out_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
                S_PARITY: begin
                    out_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (cnt_q == 4'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
`ifdef UART_TX_BREAK_EN
                        if (send_break && hold_full_q) begin
                            state_d = S_BREAK;
                            out_d   = 1'b0;
                        end else
`endif
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    if (!send_break) begin
                        out_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_STOP;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end

        // Parity is fixed at load time because the shift register is consumed as bits go out.
        if (load) begin
            shift_d     = hold_q;
            par_d       = (^hold_q) ^ (PARITY_MODE == 2);
            hold_full_d = 1'b0;
            out_d       = 1'b0;
            busy_d      = 1'b1;
            state_d     = S_START;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            par_q       <= 1'b0;
            cnt_q       <= '0;
            out_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            btick_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            par_q       <= par_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            btick_q     <= baud_tick;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: four frame formats (8N1, 8E1, 8O1, 7E2) side by side.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_tick = 1'b0;
    logic [7:0] din [3];
    logic [6:0] din7;
    logic       valid [4];
    logic       ready [4];
    logic       txo   [4];
    logic       busy  [4];
    logic       done  [4];
`ifdef UART_TX_BREAK_EN
    logic       brk   [4];
`endif

    int n_vec = 0;
    int n_err = 0;
    int done_cnt [4];
    logic obs_out  [4][40];
    logic obs_busy [4][40];
    logic obs_done [4][40];
    int cur_data [4];

    always #5 clk = ~clk;

    uart_tx_cfg #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(din[0]), .tx_valid(valid[0]),
`ifdef UART_TX_BREAK_EN
        .send_break(brk[0]),
`endif
        .tx_ready(ready[0]), .tx_out(txo[0]), .tx_busy(busy[0]), .tx_done(done[0]));

    uart_tx_cfg #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(din[1]), .tx_valid(valid[1]),
`ifdef UART_TX_BREAK_EN
        .send_break(brk[1]),
`endif
        .tx_ready(ready[1]), .tx_out(txo[1]), .tx_busy(busy[1]), .tx_done(done[1]));

    uart_tx_cfg #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(din[2]), .tx_valid(valid[2]),
`ifdef UART_TX_BREAK_EN
        .send_break(brk[2]),
`endif
        .tx_ready(ready[2]), .tx_out(txo[2]), .tx_busy(busy[2]), .tx_done(done[2]));

    uart_tx_cfg #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_7e2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .data_in(din7), .tx_valid(valid[3]),
`ifdef UART_TX_BREAK_EN
        .send_break(brk[3]),
`endif
        .tx_ready(ready[3]), .tx_out(txo[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (done[i] === 1'b1) done_cnt[i]++;
    end

    // Reference model: frame described as a sequence of line bits.
    function automatic int cfg_db(int i);
        return (i == 3) ? 7 : 8;
    endfunction
    function automatic int cfg_pm(int i);
        case (i)
            1: return 1;
            2: return 2;
            3: return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int cfg_sb(int i);
        return (i == 3) ? 2 : 1;
    endfunction
    function automatic int frame_len(int i);
        return 1 + cfg_db(i) + ((cfg_pm(i) != 0) ? 1 : 0) + cfg_sb(i);
    endfunction
    function automatic logic frame_bit(int i, int data, int k);
        int ones;
        ones = 0;
        if (k == 0) return 1'b0;
        if (k <= cfg_db(i)) return ((data >> (k - 1)) & 1) == 1;
        if (cfg_pm(i) != 0 && k == cfg_db(i) + 1) begin
            for (int b = 0; b < cfg_db(i); b++) ones += (data >> b) & 1;
            return ((ones % 2) == 1) ^ (cfg_pm(i) == 2);
        end
        return 1'b1;
    endfunction

    task automatic set_data(input int i, input int v);
        if (i == 3) din7 = 7'(v);
        else din[i] = 8'(v);
    endtask

    // One baud period of four clocks; outputs recorded one clock after the tick edge.
    task automatic do_tick(input int t);
        @(negedge clk) baud_tick = 1'b1;
        @(negedge clk) baud_tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs_out[i][t]  = txo[i];
            obs_busy[i][t] = busy[i];
            obs_done[i][t] = done[i];
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [3:0] mask);
        @(negedge clk);
        for (int i = 0; i < 4; i++) if (mask[i]) begin
            set_data(i, cur_data[i]);
            valid[i] = 1'b1;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) valid[i] = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (txo[i] !== 1'b1 || busy[i] !== 1'b0 || ready[i] !== 1'b1 || done[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset inst%0d: out/busy/ready/done got %b%b%b%b want 1010",
                         i, txo[i], busy[i], ready[i], done[i]);
            end
        end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_frames;
        int d0 [4];
        logic eo, eb, ed;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 4; i++)
                cur_data[i] = (it == 0) ? ((i == 3) ? 'h41 : 'hA5) : int'($urandom_range(0, 255));
            load(4'hF);
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (ready[i] !== 1'b0) begin
                    n_err++;
                    $display("FAIL frame_ready_low inst%0d: got %b want 0", i, ready[i]);
                end
                d0[i] = done_cnt[i];
            end
            for (int t = 1; t <= 12; t++) do_tick(t);
            for (int i = 0; i < 4; i++) begin
                for (int t = 1; t <= 12; t++) begin
                    eo = frame_bit(i, cur_data[i], t - 1);
                    eb = (t <= frame_len(i));
                    ed = (t == frame_len(i) + 1);
                    n_vec++;
                    if (obs_out[i][t] !== eo || obs_busy[i][t] !== eb || obs_done[i][t] !== ed) begin
                        n_err++;
                        $display("FAIL frame inst%0d data=%02h t=%0d: out/busy/done got %b%b%b want %b%b%b",
                                 i, cur_data[i], t, obs_out[i][t], obs_busy[i][t], obs_done[i][t], eo, eb, ed);
                    end
                end
                n_vec++;
                if (done_cnt[i] - d0[i] != 1 || ready[i] !== 1'b1) begin
                    n_err++;
                    $display("FAIL frame_done_count inst%0d: pulses %0d ready %b want 1 pulse ready 1",
                             i, done_cnt[i] - d0[i], ready[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        int a, b, d0;
        logic eo, eb, ed;
        for (int it = 0; it < 2; it++) begin
            a = (it == 0) ? 'h55 : int'($urandom_range(0, 255));
            b = (it == 0) ? 'h0F : int'($urandom_range(0, 255));
            @(negedge clk);
            set_data(0, a);
            valid[0] = 1'b1;
            @(negedge clk);
            n_vec++;
            if (ready[0] !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_first_accept: ready got %b want 0", ready[0]);
            end
            set_data(0, b);
            d0 = done_cnt[0];
            do_tick(1);
            valid[0] = 1'b0;
            n_vec++;
            if (ready[0] !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_second_accept: ready got %b want 0", ready[0]);
            end
            for (int t = 2; t <= 21; t++) do_tick(t);
            for (int t = 1; t <= 21; t++) begin
                if (t <= 10) eo = frame_bit(0, a, t - 1);
                else if (t <= 20) eo = frame_bit(0, b, t - 11);
                else eo = 1'b1;
                eb = (t <= 20);
                ed = (t == 11 || t == 21);
                n_vec++;
                if (obs_out[0][t] !== eo || obs_busy[0][t] !== eb || obs_done[0][t] !== ed) begin
                    n_err++;
                    $display("FAIL b2b %02h,%02h t=%0d: out/busy/done got %b%b%b want %b%b%b",
                             a, b, t, obs_out[0][t], obs_busy[0][t], obs_done[0][t], eo, eb, ed);
                end
            end
            n_vec++;
            if (done_cnt[0] - d0 != 2) begin
                n_err++;
                $display("FAIL b2b_done_count: got %0d want 2", done_cnt[0] - d0);
            end
        end
    endtask

    task automatic test_tick_hold_reset;
        int data, d0;
        logic eo;
        // Bits 3,4,5 fixed to 1,0,1 so a multi-bit advance is visible.
        data = int'(($urandom & 'hC7) | 'h28);
        cur_data[0] = data;
        load(4'h1);
        for (int t = 1; t <= 4; t++) do_tick(t);
        n_vec++;
        if (obs_out[0][4] !== frame_bit(0, data, 3)) begin
            n_err++;
            $display("FAIL hold_bit2: got %b want %b", obs_out[0][4], frame_bit(0, data, 3));
        end
        @(negedge clk) baud_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk) baud_tick = 1'b0;
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (txo[0] !== frame_bit(0, data, 4)) begin
                n_err++;
                $display("FAIL held_tick clk%0d: out got %b want %b", c, txo[0], frame_bit(0, data, 4));
            end
            @(negedge clk);
        end
        cur_data[0] = int'($urandom_range(0, 255));
        load(4'h1);
        n_vec++;
        if (ready[0] !== 1'b0) begin
            n_err++;
            $display("FAIL pending_accept: ready got %b want 0", ready[0]);
        end
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (txo[i] !== 1'b1 || ready[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
                n_err++;
                $display("FAIL async_reset inst%0d: out/ready/busy/done got %b%b%b%b want 1100",
                         i, txo[i], ready[i], busy[i], done[i]);
            end
        end
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        do_tick(1);
        n_vec++;
        if (obs_out[0][1] !== 1'b1 || obs_busy[0][1] !== 1'b0) begin
            n_err++;
            $display("FAIL pending_discarded: out/busy got %b%b want 10", obs_out[0][1], obs_busy[0][1]);
        end
        cur_data[0] = 'h3C;
        load(4'h1);
        d0 = done_cnt[0];
        for (int t = 1; t <= 11; t++) do_tick(t);
        for (int t = 1; t <= 11; t++) begin
            eo = frame_bit(0, 'h3C, t - 1);
            n_vec++;
            if (obs_out[0][t] !== eo || obs_busy[0][t] !== (t <= 10)) begin
                n_err++;
                $display("FAIL post_reset_frame t=%0d: out/busy got %b%b want %b%b",
                         t, obs_out[0][t], obs_busy[0][t], eo, (t <= 10));
            end
        end
        n_vec++;
        if (done_cnt[0] - d0 != 1) begin
            n_err++;
            $display("FAIL post_reset_done: got %0d want 1", done_cnt[0] - d0);
        end
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break;
        int d0;
        logic eo, eb, ed;
        cur_data[0] = 'h12;
        load(4'h1);
        d0 = done_cnt[0];
        brk[0] = 1'b1;
        for (int t = 1; t <= 5; t++) do_tick(t);
        brk[0] = 1'b0;
        for (int t = 6; t <= 17; t++) do_tick(t);
        for (int t = 1; t <= 17; t++) begin
            if (t <= 5) eo = 1'b0;
            else if (t == 6) eo = 1'b1;
            else eo = frame_bit(0, 'h12, t - 7);
            eb = (t <= 16);
            ed = (t == 7 || t == 17);
            n_vec++;
            if (obs_out[0][t] !== eo || obs_busy[0][t] !== eb || obs_done[0][t] !== ed) begin
                n_err++;
                $display("FAIL break t=%0d: out/busy/done got %b%b%b want %b%b%b",
                         t, obs_out[0][t], obs_busy[0][t], obs_done[0][t], eo, eb, ed);
            end
        end
        n_vec++;
        if (done_cnt[0] - d0 != 2) begin
            n_err++;
            $display("FAIL break_done_count: got %0d want 2", done_cnt[0] - d0);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            valid[i] = 1'b0;
            done_cnt[i] = 0;
`ifdef UART_TX_BREAK_EN
            brk[i] = 1'b0;
`endif
        end
        for (int i = 0; i < 3; i++) din[i] = '0;
        din7 = '0;
        test_reset();
        test_frames();
        test_back_to_back();
        test_tick_hold_reset();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, the next generation of the fixed 8N1 transmitter. Frame format is set at elaboration: data bits, parity and stop bits. A one-entry holding register with a valid/ready handshake lets frames go out back-to-back with no idle gap. It sits between the host-side byte source and the serial pin and shares the external baud-tick generator.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9; out-of-range values fail elaboration.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd; 3 fails elaboration.
STOP_BITS, 1, stop bits per frame; 1 or 2; other values fail elaboration.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-low reset.
baud_tick  in  1  bit-rate strobe; its rising edge is detected internally, so a level held high counts as one tick.
data_in  in  DATA_BITS  frame payload, sent LSB first.
tx_valid  in  1  payload valid.
tx_ready  out  1  holding register empty; a handshake occurs when tx_valid and tx_ready are both high at a clk edge.
tx_out  out  1  serial line; idle and mark level is 1.
tx_busy  out  1  frame on the line.
tx_done  out  1  one-clk pulse when the last stop bit completes.

Behaviour:
- Reset (async, rst=0): tx_out=1, tx_busy=0, tx_ready=1, tx_done=0. State=IDLE, hold empty, shift register and bit counter cleared. Reset mid-frame returns the line to 1 immediately; any pending hold data is discarded.
- tick = baud_tick & ~baud_tick_q, where baud_tick_q is a registered copy of baud_tick (reset 0). All frame progression happens only on a tick cycle.
- Handshake is evaluated every clk, independent of tick. On accept, data_in is latched into the hold register and tx_ready goes 0 on the next cycle. tx_ready is !hold_full.
- States: IDLE, START, DATA, PARITY, STOP.
- Each state's line value is registered on the tick that enters the state and held for one tick period. The bit counter holds for the tick period.
- IDLE: on a tick with hold_full, move hold to the shift register, clear hold_full, set tx_out<=0 and tx_busy<=1, and go to START. With no pending data, tx_out stays 1.
- START: on the next tick, tx_out<=bit0 and go to DATA.
- DATA: one bit per tick. After bit DATA_BITS-1 has been on the line for a full tick period, go to PARITY if PARITY_MODE≠0, otherwise go to STOP.
- PARITY: even mode sends the XOR of the data bits; odd mode sends its inverse.
- STOP: tx_out=1 for STOP_BITS tick periods.
- On the tick ending the final stop bit, tx_done=1 for exactly that clk.
  - If hold_full: go directly to START with tx_out<=0 and tx_busy held at 1 (no idle gap).
  - Otherwise: go to IDLE with tx_busy<=0.
- Frame length = 1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS tick periods.
- Simultaneous accept and hold unload in one cycle cannot occur, because tx_ready=0 whenever hold_full=1. A new accept is possible from the cycle after the unload.
- tx_valid dropping before a handshake has no effect. data_in is ignored except on the accept cycle.

Optional Feature:
UART_TX_BREAK_EN:
- When defined, the block adds input port send_break (1 bit) and a BREAK state.
- A tick in IDLE with send_break=1 enters BREAK: tx_out<=0, tx_busy<=1. send_break takes priority over pending hold data.
- BREAK holds the line low while send_break=1. The first tick with send_break=0 enters STOP and sends STOP_BITS mark bits, then follows normal STOP exit rules, with tx_done pulsed.
- send_break asserted mid-frame takes effect only after the current frame ends, via IDLE or in place of the direct START.
- The hold register keeps accepting data during BREAK.
- When undefined, there is no send_break port and no BREAK state.

Test Plan:
- 8N1, send 0xA5 → tx_out over successive ticks: 0,1,0,1,0,0,1,0,1,1; tx_done pulses once; tx_busy spans 10 ticks.
- PARITY_MODE=1, 8E1, send 0xA5 → parity bit 0. With PARITY_MODE=2, 0xA5 → parity bit 1. Both frames are 11 ticks.
- DATA_BITS=7, PARITY_MODE=1, STOP_BITS=2, send 0x41 → 0,1,0,0,0,0,0,1,0,1,1.
- Back-to-back 8N1: 0x55 then 0x0F, with tx_valid held → second start bit on the tick immediately after the first stop bit; 20 ticks total; two tx_done pulses; tx_busy never drops between frames.
- baud_tick held high 3 clks and rst pulsed low during DATA bit 3 → held tick advances exactly one bit; reset gives tx_out=1, tx_ready=1, tx_busy=0 immediately; the next 0x3C sends a clean frame.
- UART_TX_BREAK_EN defined: send_break high for 5 ticks while 0x12 is pending → line low for 5 ticks, 1 mark tick, then the 0x12 frame.
